// File: rtl/carus_bank_arbiter.sv
// Round-robin arbiter between the host and the vector engine for one shared Carus SRAM bank,
// with a drain / retention / wake-up power sequence that blocks grants outside ACTIVE.
module carus_bank_arbiter #(
  parameter int  NUM_WORDS   = 1024,
  parameter int  WAKE_CYCLES = 2,
  localparam int AddrWidth   = (NUM_WORDS <= 1) ? 1 : $clog2(NUM_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // host port
  input  logic                 h_req_i,
  input  logic                 h_we_i,
  input  logic [AddrWidth-1:0] h_addr_i,
  input  logic [31:0]          h_wdata_i,
  input  logic [3:0]           h_be_i,
  output logic                 h_gnt_o,
  output logic                 h_rvalid_o,
  output logic [31:0]          h_rdata_o,
  // vector-engine port
  input  logic                 v_req_i,
  input  logic                 v_we_i,
  input  logic [AddrWidth-1:0] v_addr_i,
  input  logic [31:0]          v_wdata_i,
  input  logic [3:0]           v_be_i,
  output logic                 v_gnt_o,
  output logic                 v_rvalid_o,
  output logic [31:0]          v_rdata_o,
  // retention handshake
  input  logic                 ret_req_i,
  output logic                 ret_ack_o,
  // SRAM wrapper
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  output logic                 mem_set_retentive_no,
  input  logic [31:0]          mem_rdata_i
);

  typedef enum logic [1:0] {ACTIVE, DRAIN, RET, WAKE} state_e;

  state_e     state_q, state_d;
  logic       ptr_q;    // 0: host has priority, 1: vector engine has priority
  logic       pend_q;   // a grant happened last cycle, response due now
  logic       owner_q;  // 0: host, 1: vector engine
  logic [3:0] cnt_q, cnt_d;

  logic gnt_en, sel_v, h_gnt, v_gnt, any_gnt, resp_ok;

  // Grants are suppressed in the cycle ret_req_i is seen so the drain starts clean.
  assign gnt_en  = (state_q == ACTIVE) && !ret_req_i && !rst_i;
  assign sel_v   = v_req_i && (!h_req_i || ptr_q);
  assign h_gnt   = h_req_i && !sel_v && gnt_en;
  assign v_gnt   = v_req_i && sel_v && gnt_en;
  assign any_gnt = h_gnt || v_gnt;

  assign h_gnt_o = h_gnt;
  assign v_gnt_o = v_gnt;

  // Reset kills an in-flight response in the same cycle.
  assign resp_ok    = pend_q && !rst_i;
  assign h_rvalid_o = resp_ok && !owner_q;
  assign v_rvalid_o = resp_ok && owner_q;
  assign h_rdata_o  = h_rvalid_o ? mem_rdata_i : 32'h0;
  assign v_rdata_o  = v_rvalid_o ? mem_rdata_i : 32'h0;

  assign ret_ack_o            = (state_q == RET) && !rst_i;
  assign mem_set_retentive_no = !ret_ack_o;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    mem_be_o    = 4'h0;
    if (h_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = h_we_i;
      mem_addr_o  = h_addr_i;
      mem_wdata_o = h_wdata_i;
      mem_be_o    = h_be_i;
    end else if (v_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = v_we_i;
      mem_addr_o  = v_addr_i;
      mem_wdata_o = v_wdata_i;
      mem_be_o    = v_be_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACTIVE: if (ret_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!ret_req_i)   state_d = ACTIVE;
        else if (!pend_q) state_d = RET;
      end
      RET: begin
        if (!ret_req_i) begin
          state_d = WAKE;
          cnt_d   = 4'(WAKE_CYCLES - 1);
        end
      end
      WAKE: begin
        if (cnt_q == 4'd0) state_d = ACTIVE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= ACTIVE;
      ptr_q   <= 1'b0;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= any_gnt;
      if (any_gnt) begin
        owner_q <= v_gnt;
        ptr_q   <= h_gnt;  // priority passes to whoever was not served
      end
    end
  end

endmodule

// File: tb/tb_carus_bank_arbiter.sv
// Self-checking bench for carus_bank_arbiter: a directed vector table, hand-written corner
// sequences and a randomized run compared against a transaction-level reference model.
module tb_carus_bank_arbiter;

  localparam int AW   = 10;
  localparam int WAKE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          h_req, h_we, v_req, v_we, ret_req;
  logic [AW-1:0] h_addr, v_addr;
  logic [31:0]   h_wdata, v_wdata, mem_rdata;
  logic [3:0]    h_be, v_be;
  logic          h_gnt, h_rvalid, v_gnt, v_rvalid, ret_ack;
  logic [31:0]   h_rdata, v_rdata, mem_wdata;
  logic          mem_req, mem_we, mem_retn;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  always #5 clk = ~clk;

  carus_bank_arbiter #(.NUM_WORDS(1024), .WAKE_CYCLES(WAKE)) dut (
    .clk_i(clk), .rst_i(rst),
    .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata), .h_be_i(h_be),
    .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid), .h_rdata_o(h_rdata),
    .v_req_i(v_req), .v_we_i(v_we), .v_addr_i(v_addr), .v_wdata_i(v_wdata), .v_be_i(v_be),
    .v_gnt_o(v_gnt), .v_rvalid_o(v_rvalid), .v_rdata_o(v_rdata),
    .ret_req_i(ret_req), .ret_ack_o(ret_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_set_retentive_no(mem_retn), .mem_rdata_i(mem_rdata)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one full clock: inputs are driven at the falling edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst, h, v, ret;
    logic [5:0] exp;  // {h_gnt, v_gnt, h_rvalid, v_rvalid, ret_ack, mem_set_retentive_no}
  } vec_t;

  function automatic vec_t mk(input bit r, input bit h, input bit v, input bit t, input logic [5:0] e);
    vec_t x;
    x.rst = r; x.h = h; x.v = v; x.ret = t; x.exp = e;
    return x;
  endfunction

  // Reference model state (transaction level)
  typedef enum {M_ON, M_DRAIN, M_OFF, M_WAKE} phase_e;
  phase_e phase;
  bit     resp_q[$];  // owners of responses due next cycle
  bit     turn;       // requester that wins a tie
  int     wake_left;

  initial begin
    vec_t tbl[21];
    int   win;
    bit   h_done, v_done, had_resp;
    bit   e_hg, e_vg, e_hrv, e_vrv, e_ack;
    logic [5:0]    e_ctl;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;

    rst = 1'b1; h_req = 1'b0; v_req = 1'b0; h_we = 1'b0; v_we = 1'b0; ret_req = 1'b0;
    h_addr = '0; v_addr = '0; h_wdata = '0; v_wdata = '0; h_be = 4'hF; v_be = 4'hF;
    mem_rdata = 32'h0;
    @(negedge clk);
    tick();

    // ---------------- table: arbitration and the full retention cycle ----------------
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 6'b000001);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b100001);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b011001);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b100101);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b011001);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b100101);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 6'b011001);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b100101);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'b001001);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'b000001);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'b000010);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'b000010);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b000010);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b100001);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'b001001);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'b000001);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 6'b000001);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 6'b010001);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);

    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; h_req = tbl[i].h; v_req = tbl[i].v; ret_req = tbl[i].ret;
      #1;
      check($sformatf("tbl[%0d]", i), 64'({h_gnt, v_gnt, h_rvalid, v_rvalid, ret_ack, mem_retn}),
            64'(tbl[i].exp));
      tick();
    end

    // ---------------- host read at 0x10 ----------------
    rst = 1'b1; h_req = 1'b0; v_req = 1'b0; ret_req = 1'b0;
    tick();
    rst = 1'b0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 10'h010; mem_rdata = 32'h1234_5678;
    #1;
    check("hrd_ctl", 64'({h_gnt, v_gnt, mem_req, mem_we}), 64'(4'b1010));
    check("hrd_addr", 64'(mem_addr), 64'h10);
    tick();
    h_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("hrd_rv", 64'({h_rvalid, v_rvalid, mem_req}), 64'(3'b100));
    check("hrd_data", {h_rdata, v_rdata}, {32'hCAFE_F00D, 32'h0});
    tick();

    // ---------------- vector write, be=0101 ----------------
    v_req = 1'b1; v_we = 1'b1; v_be = 4'b0101; v_wdata = 32'hDEAD_BEEF; v_addr = 10'h3FF;
    #1;
    check("vwr_ctl", 64'({v_gnt, h_gnt, mem_req, mem_we, mem_be}), 64'(8'b1011_0101));
    check("vwr_data", 64'({mem_wdata, mem_addr}), 64'({32'hDEAD_BEEF, 10'h3FF}));
    tick();
    v_req = 1'b0; v_we = 1'b0;
    #1;
    check("vwr_rv", 64'({v_rvalid, h_rvalid}), 64'(2'b10));
    check("vwr_idle_mem", 64'({mem_req, mem_we, mem_be, mem_addr}), 64'h0);
    tick();

    // ---------------- reset in the response cycle ----------------
    h_req = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("rst_gnt", 64'(h_gnt), 64'h1);
    tick();
    h_req = 1'b0; rst = 1'b1;
    #1;
    check("rst_drop", 64'({h_rvalid, v_rvalid, h_rdata, v_rdata}), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_after", 64'({h_gnt, v_gnt, h_rvalid, v_rvalid, ret_ack, mem_retn, mem_req, mem_we}),
          64'(8'b0000_0100));
    check("rst_after_data", {h_rdata, v_rdata}, 64'h0);
    tick();

    // ---------------- randomized run against the reference model ----------------
    h_req = 1'b0; v_req = 1'b0; h_done = 1'b0; v_done = 1'b0;
    phase = M_ON; resp_q = {}; turn = 1'b0; wake_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (h_done) h_req = 1'b0;
      if (v_done) v_req = 1'b0;
      if (!h_req) begin
        h_req = ($urandom_range(0, 2) != 0);
        h_we = 1'($urandom); h_addr = AW'($urandom); h_wdata = $urandom; h_be = 4'($urandom);
      end
      if (!v_req) begin
        v_req = ($urandom_range(0, 2) != 0);
        v_we = 1'($urandom); v_addr = AW'($urandom); v_wdata = $urandom; v_be = 4'($urandom);
      end
      if ($urandom_range(0, 24) == 0) ret_req = !ret_req;
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      mem_rdata = $urandom;
      #1;

      win = -1;
      if (phase == M_ON && !ret_req && !rst) begin
        if (h_req && v_req) win = turn ? 1 : 0;
        else if (h_req)     win = 0;
        else if (v_req)     win = 1;
      end
      e_hg  = (win == 0);
      e_vg  = (win == 1);
      e_hrv = !rst && resp_q.size() > 0 && resp_q[0] == 1'b0;
      e_vrv = !rst && resp_q.size() > 0 && resp_q[0] == 1'b1;
      e_ack = !rst && phase == M_OFF;
      e_ctl = 6'h0; e_addr = '0; e_wdata = 32'h0;
      if (win == 0) begin e_ctl = {1'b1, h_we, h_be}; e_addr = h_addr; e_wdata = h_wdata; end
      if (win == 1) begin e_ctl = {1'b1, v_we, v_be}; e_addr = v_addr; e_wdata = v_wdata; end

      check("rnd_ctl", 64'({h_gnt, v_gnt, h_rvalid, v_rvalid, ret_ack, mem_retn}),
            64'({e_hg, e_vg, e_hrv, e_vrv, e_ack, !e_ack}));
      check("rnd_mem", 64'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}),
            64'({e_ctl, e_addr, e_wdata}));
      check("rnd_rdata", {h_rdata, v_rdata},
            {e_hrv ? mem_rdata : 32'h0, e_vrv ? mem_rdata : 32'h0});

      had_resp = resp_q.size() > 0;
      resp_q = {};
      h_done = e_hg;
      v_done = e_vg;
      if (rst) begin
        phase = M_ON; turn = 1'b0; wake_left = 0;
      end else begin
        if (win >= 0) begin
          resp_q.push_back(win == 1);
          turn = (win == 0);
        end
        case (phase)
          M_ON:    if (ret_req) phase = M_DRAIN;
          M_DRAIN: if (!ret_req) phase = M_ON; else if (!had_resp) phase = M_OFF;
          M_OFF:   if (!ret_req) begin phase = M_WAKE; wake_left = WAKE; end
          M_WAKE: begin
            wake_left--;
            if (wake_left == 0) phase = M_ON;
          end
          default: phase = M_ON;
        endcase
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/carus_bank_arbiter.md
CARUS_BANK_ARBITER -- requirements
Module: carus_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1024, number of 32-bit words in the shared Carus SRAM bank.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, range 1..15, wake-up blanking cycles after leaving retention.
REQ-003 SHALL have derived localparam AddrWidth = clog2(NUM_WORDS), or 1 when NUM_WORDS <= 1; it SHALL NOT be overridable.
REQ-004 SHALL have clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have h_req_i, h_we_i (1), h_addr_i (AddrWidth), h_wdata_i (32) and h_be_i (4) as inputs, forming the host requester port.
REQ-007 SHALL have h_gnt_o, h_rvalid_o (1) and h_rdata_o (32) as outputs, forming the host response.
REQ-008 SHALL have v_req_i, v_we_i, v_addr_i, v_wdata_i, v_be_i as inputs and v_gnt_o, v_rvalid_o, v_rdata_o as outputs, forming the vector-engine port, with widths as on the host port.
REQ-009 SHALL have ret_req_i, input, 1, retention request (level).
REQ-010 SHALL have ret_ack_o, output, 1, bank is in retention.
REQ-011 SHALL have mem_req_o, mem_we_o (1), mem_addr_o (AddrWidth), mem_wdata_o (32) and mem_be_o (4) as outputs driving the SRAM wrapper.
REQ-012 SHALL have mem_set_retentive_no, output, 1, active-low retention control to the SRAM wrapper.
REQ-013 SHALL have mem_rdata_i, input, 32, SRAM read data, valid one cycle after the request.

Function
REQ-014 SHALL grant at most one requester per cycle; the grant is combinational in the cycle of the request (gnt = req & selected & grant-enable).
REQ-015 SHALL forward the granted requester's we/addr/wdata/be to mem_* and assert mem_req_o in the grant cycle; with no grant, mem_req_o and mem_we_o = 0 and mem_addr_o, mem_wdata_o, mem_be_o = 0.
REQ-016 SHALL arbitrate round-robin: 1-bit priority pointer; on simultaneous requests the pointed requester wins; after any grant the pointer moves to the other requester; the pointer holds when there is no grant.
REQ-017 SHALL register the grant owner and assert exactly one rvalid (h_ or v_) in the cycle after every grant, reads and writes alike; rvalid is a 1-cycle pulse.
REQ-018 SHALL drive the owner's rdata_o = mem_rdata_i in the rvalid cycle, and 0 otherwise; the non-owner's rdata_o = 0.
REQ-019 SHALL accept back-to-back grants: a grant in cycle N+1 overlaps rvalid for the grant of cycle N.
REQ-020 SHALL implement FSM ACTIVE, DRAIN, RET, WAKE; grant-enable is 1 only in ACTIVE.
REQ-021 In ACTIVE with ret_req_i=1, the FSM SHALL move to DRAIN next cycle; no grant is issued in the ret_req_i cycle itself.
REQ-022 In DRAIN, the FSM SHALL move to RET once no response is pending (pending = grant in previous cycle); if ret_req_i drops first, it SHALL return to ACTIVE.
REQ-023 In RET, mem_set_retentive_no = 0 and ret_ack_o = 1; when ret_req_i=0, the FSM SHALL move to WAKE.
REQ-024 In WAKE, mem_set_retentive_no = 1 and ret_ack_o = 0; a 4-bit counter loads WAKE_CYCLES-1 on entry and the FSM SHALL go to ACTIVE after it reaches 0, giving exactly WAKE_CYCLES cycles in WAKE; ret_req_i is ignored in WAKE.
REQ-025 Outside RET, mem_set_retentive_no SHALL be 1.
REQ-026 Requests arriving in DRAIN, RET or WAKE SHALL stay ungranted and are not lost (requesters hold req until gnt).

Reset
REQ-027 While rst_i=1 at a clock edge: FSM=ACTIVE, pointer=host, pending/owner cleared, counter=0.
REQ-028 After reset: all gnt/rvalid/rdata/mem_* outputs = 0, ret_ack_o = 0, mem_set_retentive_no = 1; gnt and mem_req_o are forced 0 while rst_i=1.
REQ-029 Reset during a pending response SHALL drop that rvalid; reset in RET or WAKE SHALL return to ACTIVE immediately.

Verification
REQ-030 Host-only read addr 0x10 -> h_gnt_o and mem_req_o in cycle N, h_rvalid_o with h_rdata_o = mem_rdata_i in N+1, v_* idle.
REQ-031 Both requesting continuously for 6 cycles after reset -> grants alternate H,V,H,V,H,V; each rvalid goes to the matching port one cycle later.
REQ-032 Write be=4'b0101 data 0xDEADBEEF from V -> mem_we_o=1, mem_be_o=0x5, mem_wdata_o=0xDEADBEEF; v_rvalid_o pulses next cycle.
REQ-033 Grant at N, ret_req_i rises at N+1 -> DRAIN at N+2, RET at N+3 with mem_set_retentive_no=0 and ret_ack_o=1; the pending rvalid is still delivered at N+1.
REQ-034 ret_req_i falls in RET with a host request held -> WAKE for 2 cycles (no grant), then grant in the first ACTIVE cycle.
REQ-035 rst_i asserted in the cycle after a grant -> no rvalid, all outputs at reset values next cycle.
